// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: 4-digit common-anode seven-segment scan controller.
// Ports: clk, rst (sync, active high), digits_in[11:0] (digit0 in [2:0]),
//   load (capture strobe), blink_mask[3:0] (only with SSEG_BLINK_EN),
//   an[3:0] (active-low anodes), point[2:0] (decoder code),
//   frame_done (1-cycle pulse at each frame boundary).
// Optional macro SSEG_BLINK_EN adds per-digit blinking via a frame counter.
module sseg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
`ifdef SSEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 125
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] digits_in,
    input  logic        load,
`ifdef SSEG_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    output logic [3:0]  an,
    output logic [2:0]  point,
    output logic        frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [11:0]   DASHES     = {4{3'b101}};

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic          wrap;
    logic [11:0]   active, active_n;
    logic [11:0]   shadow;
    logic          pending;
    logic [3:0]    an_n;

`ifdef SSEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] fcnt;
    logic          phase;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        wrap     = 1'b0;
        active_n = active;
        an_n     = 4'b1111;

        unique case (state)
            BLANK: begin
                if (cnt == BLANK_LAST)
                    state_n = DRIVE;
            end
            DRIVE: begin
                if (cnt == SLOT_LAST) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    idx_n   = idx + 2'd1;
                    wrap    = (idx == 2'd3);
                end
            end
        endcase

        // A load landing on the boundary cycle bypasses the shadow.
        if (wrap) begin
            if (load)
                active_n = digits_in;
            else if (pending)
                active_n = shadow;
        end

        // Outputs are registered from next-cycle values so an/point
        // line up with the slot the counter is about to enter.
        if (state_n == DRIVE)
            an_n[idx_n] = 1'b0;

`ifdef SSEG_BLINK_EN
        if (phase && blink_mask[idx_n])
            an_n = 4'b1111;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= 2'd0;
            active     <= DASHES;
            shadow     <= DASHES;
            pending    <= 1'b0;
            an         <= 4'b1111;
            point      <= 3'b101;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            active     <= active_n;
            an         <= an_n;
            point      <= active_n[3*idx_n +: 3];
            frame_done <= wrap;
            if (load)
                shadow <= digits_in;
            if (wrap)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;
        end
    end

`ifdef SSEG_BLINK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            if (fcnt == FRAME_LAST) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: directed table, reset and blink sequences, and
// random loads checked against a cycle-index reference model.
module tb_sseg_scan_ctrl;

    localparam int RD = 10;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int FR = 4 * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [11:0] digits_in = '0;
    logic [3:0]  an;
    logic [2:0]  point;
    logic        frame_done;
`ifdef SSEG_BLINK_EN
    logic [3:0]  blink_mask = 4'b0000;
`endif

    sseg_scan_ctrl #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
`ifdef SSEG_BLINK_EN
        ,
        .BLINK_FRAMES(BF)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits_in (digits_in),
        .load      (load),
`ifdef SSEG_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .an        (an),
        .point     (point),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic        ld;
        logic [11:0] din;
        logic [3:0]  an;
        logic [2:0]  pt;
        logic        fd;
    } vec_t;

    vec_t vecs[$];

    int tests = 0;
    int fails = 0;
    int t = 0;
    bit use_model = 1'b0;

    logic [2:0] m_act[4];
    logic [2:0] m_sh[4];
    bit         m_pend;

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0d got an/pt/fd=%b required %b",
                     name, t, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_act[k] = 3'b101;
            m_sh[k]  = 3'b101;
        end
        m_pend = 1'b0;
    endtask

    function automatic logic [7:0] model_out();
        int          slot;
        int          pos;
        logic [3:0]  e_an;
        logic        e_fd;
        slot = (t / RD) % 4;
        pos  = t % RD;
        e_an = (pos < BC) ? 4'b1111 : ~(4'b0001 << slot);
`ifdef SSEG_BLINK_EN
        if (((t / FR) / BF) % 2 == 1 && blink_mask[slot])
            e_an = 4'b1111;
`endif
        e_fd = (t > 0) && (t % FR == 0);
        return {e_an, m_act[slot], e_fd};
    endfunction

    task automatic tick(input logic ld, input logic [11:0] din);
        load      = ld;
        digits_in = din;
        if (use_model)
            check("model", {an, point, frame_done}, model_out());
        if (t % FR == FR - 1) begin
            for (int k = 0; k < 4; k++) begin
                if (ld)
                    m_act[k] = din[3*k +: 3];
                else if (m_pend)
                    m_act[k] = m_sh[k];
            end
            m_pend = 1'b0;
        end else if (ld) begin
            for (int k = 0; k < 4; k++)
                m_sh[k] = din[3*k +: 3];
            m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        t++;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t   = 0;
        model_reset();
    endtask

    task automatic add(input int tt, input logic ld, input logic [11:0] d,
                       input logic [3:0] a, input logic [2:0] p,
                       input logic f);
        vec_t v;
        v.t = tt; v.ld = ld; v.din = d; v.an = a; v.pt = p; v.fd = f;
        vecs.push_back(v);
    endtask

    localparam logic [11:0] D1 = 12'b100_011_010_001;
    localparam logic [11:0] DA = 12'b110_110_110_110;
    localparam logic [11:0] DB = 12'b010_001_000_011;

    initial begin
        logic [3:0] blink_exp[5];

        add(0,   0, 0,      4'b1111, 3'b101, 0);
        add(1,   0, 0,      4'b1111, 3'b101, 0);
        add(2,   0, 0,      4'b1110, 3'b101, 0);
        add(9,   0, 0,      4'b1110, 3'b101, 0);
        add(10,  0, 0,      4'b1111, 3'b101, 0);
        add(12,  0, 0,      4'b1101, 3'b101, 0);
        add(15,  1, D1,     4'b1101, 3'b101, 0);
        add(22,  0, 0,      4'b1011, 3'b101, 0);
        add(35,  0, 0,      4'b0111, 3'b101, 0);
        add(39,  0, 0,      4'b0111, 3'b101, 0);
        add(40,  0, 0,      4'b1111, 3'b001, 1);
        add(41,  0, 0,      4'b1111, 3'b001, 0);
        add(42,  0, 0,      4'b1110, 3'b001, 0);
        add(45,  1, DA,     4'b1110, 3'b001, 0);
        add(50,  0, 0,      4'b1111, 3'b010, 0);
        add(60,  0, 0,      4'b1111, 3'b011, 0);
        add(70,  1, DB,     4'b1111, 3'b100, 0);
        add(72,  0, 0,      4'b0111, 3'b100, 0);
        add(79,  0, 0,      4'b0111, 3'b100, 0);
        add(80,  0, 0,      4'b1111, 3'b011, 1);
        add(90,  0, 0,      4'b1111, 3'b000, 0);
        add(100, 0, 0,      4'b1111, 3'b001, 0);
        add(105, 1, 12'hFFF, 4'b1011, 3'b001, 0);
        add(110, 0, 0,      4'b1111, 3'b010, 0);
        add(119, 1, 12'h000, 4'b0111, 3'b010, 0);
        add(120, 0, 0,      4'b1111, 3'b000, 1);
        add(122, 0, 0,      4'b1110, 3'b000, 0);
        add(130, 0, 0,      4'b1111, 3'b000, 0);
        add(152, 0, 0,      4'b0111, 3'b000, 0);
        add(160, 0, 0,      4'b1111, 3'b000, 1);

        repeat (3) @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            while (t < vecs[i].t)
                tick(1'b0, 12'h000);
            check($sformatf("vec%0d", i), {an, point, frame_done},
                  {vecs[i].an, vecs[i].pt, vecs[i].fd});
            tick(vecs[i].ld, vecs[i].din);
        end

        // Reset mid DRIVE of slot 2 with a pending load outstanding.
        do_reset();
        while (t < 65) begin
            if (t == 5)
                tick(1'b1, 12'h000);
            else if (t == 50)
                tick(1'b1, 12'hFFF);
            else
                tick(1'b0, 12'h000);
        end
        check("pre_rst", {an, point, frame_done}, {4'b1011, 3'b000, 1'b0});
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid", {an, point, frame_done}, {4'b1111, 3'b101, 1'b0});
        rst = 1'b0;
        t   = 0;
        model_reset();
        tick(1'b0, 12'h000);
        check("rst_blank", {an, point, frame_done}, {4'b1111, 3'b101, 1'b0});
        tick(1'b0, 12'h000);
        check("rst_drive", {an, point, frame_done}, {4'b1110, 3'b101, 1'b0});
        while (t < 40)
            tick(1'b0, 12'h000);
        check("rst_nopend", {an, point, frame_done}, {4'b1111, 3'b101, 1'b1});

`ifdef SSEG_BLINK_EN
        blink_exp = '{4'b1110, 4'b1110, 4'b1111, 4'b1111, 4'b1110};
        blink_mask = 4'b0001;
        do_reset();
        for (int f = 0; f < 5; f++) begin
            while (t < f * FR + 5)
                tick(1'b0, 12'h000);
            check($sformatf("blink_d0_f%0d", f), {an, point, frame_done},
                  {blink_exp[f], 3'b101, 1'b0});
            while (t < f * FR + 15)
                tick(1'b0, 12'h000);
            check($sformatf("blink_d1_f%0d", f), {an, point, frame_done},
                  {4'b1101, 3'b101, 1'b0});
        end
`else
        blink_exp = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110};
        do_reset();
        for (int f = 0; f < 5; f++) begin
            while (t < f * FR + 5)
                tick(1'b0, 12'h000);
            check($sformatf("noblink_f%0d", f), {an, point, frame_done},
                  {blink_exp[f], 3'b101, 1'b0});
        end
`endif

        use_model = 1'b1;
        for (int r = 0; r < 3; r++) begin
`ifdef SSEG_BLINK_EN
            blink_mask = 4'($urandom);
`endif
            do_reset();
            for (int c = 0; c < 8 * FR; c++) begin
                logic ld;
                if (t % FR == FR - 1)
                    ld = ($urandom % 3) == 0;
                else
                    ld = ($urandom % 12) == 0;
                tick(ld, 12'($urandom));
            end
        end
        use_model = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
